// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter for the shared data memory. Port 0 is the
// pipeline MEM stage, port 1 a secondary bus master. The granted request is
// turned into a word address, byte enables and lane-shifted store data, and
// a read-valid or error response is returned one cycle after each grant.
module dm_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [1:0]  width0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [1:0]  width1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic        m_data_rd,
  input  logic [31:0] m_data_rdata
);

  localparam logic [1:0] WIDTH_WORD = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_BYTE = 2'b10;

  // Alignment rule: words on 4-byte, halves on 2-byte boundaries, bytes
  // anywhere; the fourth width code is never legal.
  function automatic logic access_legal(input logic [1:0] width,
                                        input logic [1:0] lo);
    case (width)
      WIDTH_WORD: access_legal = (lo == 2'b00);
      WIDTH_HALF: access_legal = ~lo[0];
      WIDTH_BYTE: access_legal = 1'b1;
      default:    access_legal = 1'b0;
    endcase
  endfunction

  // Byte lanes touched by a legal store.
  function automatic logic [3:0] lane_enables(input logic [1:0] width,
                                              input logic [1:0] lo);
    case (width)
      WIDTH_WORD: lane_enables = 4'b1111;
      WIDTH_HALF: lane_enables = lo[1] ? 4'b1100 : 4'b0011;
      WIDTH_BYTE: lane_enables = 4'b0001 << lo;
      default:    lane_enables = 4'b0000;
    endcase
  endfunction

  // Moves right-aligned store data into its lanes; unused lanes read as 0.
  function automatic logic [31:0] lane_data(input logic [1:0]  width,
                                            input logic [1:0]  lo,
                                            input logic [31:0] data);
    case (width)
      WIDTH_WORD: lane_data = data;
      WIDTH_HALF: lane_data = lo[1] ? {data[15:0], 16'h0000}
                                    : {16'h0000, data[15:0]};
      WIDTH_BYTE: lane_data = {24'h000000, data[7:0]} << {lo, 3'b000};
      default:    lane_data = 32'h0000_0000;
    endcase
  endfunction

  logic        last_gnt;
  logic        rsp_port_p1;
  logic        rsp_rd_p1;
  logic        rsp_err_p1;

  logic        granted_p0;
  logic        sel_we_p0;
  logic [31:0] sel_addr_p0;
  logic [31:0] sel_wdata_p0;
  logic [1:0]  sel_width_p0;
  logic        legal_p0;

  // Stage p0: arbitration and memory request formation (combinational).
  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    m_data_addr   = 32'h0000_0000;
    m_data_wdata  = 32'h0000_0000;
    m_data_byteen = 4'b0000;
    m_data_rd     = 1'b0;

    if (!reset) begin
      if (req0 && req1) begin
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end

    granted_p0   = gnt0 | gnt1;
    sel_we_p0    = gnt1 ? we1    : we0;
    sel_addr_p0  = gnt1 ? addr1  : addr0;
    sel_wdata_p0 = gnt1 ? wdata1 : wdata0;
    sel_width_p0 = gnt1 ? width1 : width0;
    legal_p0     = access_legal(sel_width_p0, sel_addr_p0[1:0]);

    if (granted_p0) begin
      m_data_addr = {sel_addr_p0[31:2], 2'b00};
      if (legal_p0) begin
        if (sel_we_p0) begin
          m_data_byteen = lane_enables(sel_width_p0, sel_addr_p0[1:0]);
          m_data_wdata  = lane_data(sel_width_p0, sel_addr_p0[1:0], sel_wdata_p0);
        end else begin
          m_data_rd = 1'b1;
        end
      end
    end
  end

  // Round-robin pointer and response flags; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt   <= 1'b1;
      rsp_rd_p1  <= 1'b0;
      rsp_err_p1 <= 1'b0;
    end else begin
      rsp_rd_p1  <= granted_p0 & legal_p0 & ~sel_we_p0;
      rsp_err_p1 <= granted_p0 & ~legal_p0;
      if (granted_p0) begin
        last_gnt <= gnt1;
      end
    end
  end

  // Owner of the response; only meaningful alongside the flags above.
  always_ff @(posedge clk) begin
    if (granted_p0) begin
      rsp_port_p1 <= gnt1;
    end
  end

  // Stage p1: responses, held low while reset is asserted.
  always_comb begin
    rvalid0 = ~reset & rsp_rd_p1  & ~rsp_port_p1;
    rvalid1 = ~reset & rsp_rd_p1  &  rsp_port_p1;
    err0    = ~reset & rsp_err_p1 & ~rsp_port_p1;
    err1    = ~reset & rsp_err_p1 &  rsp_port_p1;
    rdata   = m_data_rdata;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed steps from the access scenarios followed by
// constrained-random traffic, all checked against a transaction-level model
// of arbitration, lane placement, memory contents and responses.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [1:0]  width0, width1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, m_data_rd;
  logic [31:0] rdata, m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .width0(width0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .width1(width1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_data_rd(m_data_rd),
    .m_data_rdata(m_data_rdata)
  );

  // Memory environment: 256 words addressed by addr[9:2], word 0x41 (0x104)
  // preloaded with 0xDEADBEEF, reloaded whenever reset is high.
  logic [31:0] env_mem [0:255];
  logic [31:0] mrdata;
  assign m_data_rdata = mrdata;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= (i == 65) ? 32'hDEADBEEF : 32'h0;
      mrdata <= 32'h0;
    end else begin
      if (m_data_rd) mrdata <= env_mem[m_data_addr[9:2]];
      for (int i = 0; i < 4; i++)
        if (m_data_byteen[i]) env_mem[m_data_addr[9:2]][8*i +: 8] <= m_data_wdata[8*i +: 8];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:255];
  int          last_win = 1;
  int          cur_win = -1;
  bit          pend_rd = 0, pend_err = 0;
  int          pend_port = 0;
  logic [31:0] pend_data = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset_mem();
    for (int i = 0; i < 256; i++) ref_mem[i] = (i == 65) ? 32'hDEADBEEF : 32'h0;
  endtask

  // One clock: check all outputs mid-cycle against the model, then advance it.
  task automatic cycle();
    int          win, sz, lane;
    logic [31:0] a, d, ew, mask;
    logic [1:0]  w;
    logic        we, legal, store, load;
    logic [3:0]  eb;
    @(negedge clk);
    if (reset)              win = -1;
    else if (req0 && req1)  win = (last_win == 0) ? 1 : 0;
    else if (req0)          win = 0;
    else if (req1)          win = 1;
    else                    win = -1;
    cur_win = win;
    a  = (win == 1) ? addr1  : addr0;
    d  = (win == 1) ? wdata1 : wdata0;
    w  = (win == 1) ? width1 : width0;
    we = (win == 1) ? we1    : we0;
    legal = (w == 2'd0 && a[1:0] == 2'd0) || (w == 2'd1 && a[0] == 1'b0) || (w == 2'd2);
    sz   = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
    lane = (w == 2'd0) ? 0 : (w == 2'd1) ? 2 * int'(a[1]) : int'(a[1:0]);
    eb   = 4'((1 << sz) - 1) << lane;
    mask = 32'((64'd1 << (8 * sz)) - 64'd1);
    ew   = (d & mask) << (8 * lane);
    store = (win >= 0) && legal && we;
    load  = (win >= 0) && legal && !we;

    chk("gnt0", {31'b0, gnt0}, {31'b0, win == 0});
    chk("gnt1", {31'b0, gnt1}, {31'b0, win == 1});
    chk("m_data_addr", m_data_addr, (win >= 0) ? {a[31:2], 2'b00} : 32'h0);
    chk("m_data_rd", {31'b0, m_data_rd}, {31'b0, load});
    chk("m_data_byteen", {28'b0, m_data_byteen}, store ? {28'b0, eb} : 32'h0);
    if (win < 0 || legal) chk("m_data_wdata", m_data_wdata, store ? ew : 32'h0);
    chk("rvalid0", {31'b0, rvalid0}, {31'b0, !reset && pend_rd  && pend_port == 0});
    chk("rvalid1", {31'b0, rvalid1}, {31'b0, !reset && pend_rd  && pend_port == 1});
    chk("err0",    {31'b0, err0},    {31'b0, !reset && pend_err && pend_port == 0});
    chk("err1",    {31'b0, err1},    {31'b0, !reset && pend_err && pend_port == 1});
    chk("rdata_pass", rdata, m_data_rdata);
    if (!reset && pend_rd) chk("rdata_value", rdata, pend_data);

    if (reset) begin
      last_win = 1; pend_rd = 0; pend_err = 0;
      ref_reset_mem();
    end else if (win >= 0) begin
      last_win  = win;
      pend_port = win;
      pend_rd   = load;
      pend_err  = !legal;
      pend_data = ref_mem[a[9:2]];
      if (store)
        for (int i = 0; i < 4; i++)
          if (eb[i]) ref_mem[a[9:2]][8*i +: 8] = ew[8*i +: 8];
    end else begin
      pend_rd = 0; pend_err = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w_e, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] w);
    req0 = r; we0 = w_e; addr0 = a; wdata0 = d; width0 = w;
  endtask

  task automatic set1(input logic r, input logic w_e, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] w);
    req1 = r; we1 = w_e; addr1 = a; wdata1 = d; width1 = w;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    r[31:10] = ($urandom_range(0, 3) == 0) ? r[31:10] : 22'h0;
    return r;
  endfunction

  initial begin
    ref_reset_mem();
    reset = 1'b1;
    set0(0, 0, 32'h0, 32'h0, 2'b00);
    set1(0, 0, 32'h0, 32'h0, 2'b00);
    cycle(); cycle();
    reset = 1'b0;
    cycle();

    // Word load from preloaded location
    set0(1, 0, 32'h104, 32'h0, 2'b00); cycle();
    set0(0, 0, 32'h0, 32'h0, 2'b00);   cycle();

    // Byte stores into lanes 1..3 from port 1
    set1(1, 1, 32'h201, 32'hAB, 2'b10); cycle();
    set1(1, 1, 32'h202, 32'hAB, 2'b10); cycle();
    set1(1, 1, 32'h203, 32'hAB, 2'b10); cycle();
    set1(1, 0, 32'h200, 32'h0, 2'b00);  cycle();
    set1(0, 0, 32'h0, 32'h0, 2'b00);    cycle();

    // Contention for four cycles
    set0(1, 0, 32'h104, 32'h0, 2'b00);
    set1(1, 0, 32'h200, 32'h0, 2'b00);
    repeat (4) cycle();
    set0(0, 0, 32'h0, 32'h0, 2'b00);
    set1(0, 0, 32'h0, 32'h0, 2'b00);
    cycle();

    // Misaligned half and illegal width
    set0(1, 0, 32'h103, 32'h0, 2'b01); cycle();
    set0(1, 0, 32'h100, 32'h0, 2'b11); cycle();
    set0(0, 0, 32'h0, 32'h0, 2'b00);   cycle();

    // Upper half store, then read the word back
    set0(1, 1, 32'h302, 32'h1234CAFE, 2'b01); cycle();
    set0(1, 0, 32'h300, 32'h0, 2'b00);        cycle();
    set0(0, 0, 32'h0, 32'h0, 2'b00);          cycle();

    // Reset right after a granted load, then a tie
    set0(1, 0, 32'h104, 32'h0, 2'b00); cycle();
    set0(0, 0, 32'h0, 32'h0, 2'b00);
    reset = 1'b1; cycle();
    reset = 1'b0;
    set0(1, 0, 32'h104, 32'h0, 2'b00);
    set1(1, 1, 32'h208, 32'h55, 2'b10);
    cycle(); cycle();
    set0(0, 0, 32'h0, 32'h0, 2'b00);
    set1(0, 0, 32'h0, 32'h0, 2'b00);
    cycle();

    // Random traffic; a request that lost arbitration is held unchanged
    for (int n = 0; n < 400; n++) begin
      if (!req0 || cur_win == 0)
        set0($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(),
             $urandom, 2'($urandom_range(0, 3)));
      if (!req1 || cur_win == 1)
        set1($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(),
             $urandom, 2'($urandom_range(0, 3)));
      reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;
    set0(0, 0, 32'h0, 32'h0, 2'b00);
    set1(0, 0, 32'h0, 32'h0, 2'b00);
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
